// File: rtl/bp_pkg.sv
// Shared types, counter encodings and the saturating update for the branch predictor.
package bp_pkg;

    typedef logic [1:0] bp_cnt_t;

    localparam bp_cnt_t BP_SNT = 2'b00;
    localparam bp_cnt_t BP_WNT = 2'b01;
    localparam bp_cnt_t BP_WT  = 2'b10;
    localparam bp_cnt_t BP_STK = 2'b11;
    localparam bp_cnt_t BP_RST = BP_WNT;

    // Step one position toward the resolved direction, pinning at either end.
    function automatic bp_cnt_t bp_next(input bp_cnt_t cnt, input logic taken);
        bp_cnt_t res;
        res = cnt;
        if (taken) begin
            if (cnt != BP_STK) res = cnt + 2'd1;
        end else begin
            if (cnt != BP_SNT) res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_pht.sv
// Pattern history table: 2-bit saturating counters with one combinational read
// port and one synchronous training port.
module branch_pht
    import bp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEPTH_LOG2-1:0] ridx,
    output logic                  rtaken,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] widx,
    input  logic                  taken
);

    localparam int ENTRIES = 1 << DEPTH_LOG2;

    logic [ENTRIES-1:0] msbVec;

    // Counters live in flops rather than RAM: the read is combinational and
    // every entry must return to weak-not-taken on reset.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : gEntry
            bp_cnt_t cntReg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cntReg <= BP_RST;
                end else if (we && (widx == DEPTH_LOG2'(gi))) begin
                    cntReg <= bp_next(cntReg, taken);
                end
            end

            assign msbVec[gi] = cntReg[1];
        end
    endgenerate

    assign rtaken = msbVec[ridx];

endmodule

// File: rtl/branch_predict.sv
// Dynamic branch direction predictor: PHT lookup in F, prediction carried through D and E,
// training in E. Optional gshare indexing when BP_GSHARE_EN is defined.
module branch_predict
    import bp_pkg::*;
#(
    parameter int PHT_DEPTH = 6,
    parameter int PC_LSB    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        stallE,
    input  logic        flushE,
    input  logic        branchE,
    input  logic        actual_takeE,
    output logic        pred_takeD,
    output logic        succE
);

    logic [PHT_DEPTH-1:0] pcIdx;
    logic [PHT_DEPTH-1:0] idxF;
    logic [PHT_DEPTH-1:0] idxD;
    logic [PHT_DEPTH-1:0] idxE;
    logic                 predF;
    logic                 pred_takeE;
    logic                 train;
    logic                 unusedPcBits;

    assign pcIdx        = pcF[PC_LSB+PHT_DEPTH-1:PC_LSB];
    assign unusedPcBits = ^pcF;

    // A stalled E instruction trains only on the cycle it leaves E.
    assign train = branchE & ~stallE;

`ifdef BP_GSHARE_EN
    logic [PHT_DEPTH-1:0] ghr;

    // History follows resolved outcomes only, so it never needs repair.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (train) begin
            ghr <= {ghr[PHT_DEPTH-2:0], actual_takeE};
        end
    end

    assign idxF = pcIdx ^ ghr;
`else
    assign idxF = pcIdx;
`endif

    branch_pht #(
        .DEPTH_LOG2(PHT_DEPTH)
    ) uPht (
        .clk    (clk),
        .rst    (rst),
        .ridx   (idxF),
        .rtaken (predF),
        .we     (train),
        .widx   (idxE),
        .taken  (actual_takeE)
    );

    always_ff @(posedge clk) begin
        if (rst || flushD) begin
            pred_takeD <= 1'b0;
            idxD       <= '0;
        end else if (!stallD) begin
            pred_takeD <= predF;
            idxD       <= idxF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            pred_takeE <= 1'b0;
            idxE       <= '0;
        end else if (!stallE) begin
            pred_takeE <= pred_takeD;
            idxE       <= idxD;
        end
    end

    assign succE = (pred_takeE == actual_takeE);

endmodule

// File: tb/tb_branch_predict.sv
// Bench for branch_predict: directed vector table, random scoreboard phase against a
// reference model, and a gshare history check when BP_GSHARE_EN is defined.
module tb_branch_predict;

    localparam int ENTRIES = 64;
    localparam logic [31:0] PA  = 32'h0040_0000;
    localparam logic [31:0] PB  = 32'h0040_0010;
    localparam logic [31:0] P5  = 32'h0040_0014;
    localparam logic [31:0] P8  = 32'h0040_0020;
    localparam int NTBL = 35;
    localparam int NRND = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcF = 32'h0;
    logic        stallD = 1'b0, flushD = 1'b0, stallE = 1'b0, flushE = 1'b0;
    logic        branchE = 1'b0, actual_takeE = 1'b0;
    logic        pred_takeD, succE;

    always #5 clk = ~clk;

    branch_predict dut (
        .clk          (clk),
        .rst          (rst),
        .pcF          (pcF),
        .stallD       (stallD),
        .flushD       (flushD),
        .stallE       (stallE),
        .flushE       (flushE),
        .branchE      (branchE),
        .actual_takeE (actual_takeE),
        .pred_takeD   (pred_takeD),
        .succE        (succE)
    );

    typedef struct {
        logic        r;
        logic [31:0] pc;
        logic        sD, fD, sE, fE, br, act;
        logic        expD, expS;
    } vec_t;

    typedef struct {
        logic expD;
        logic expS;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[NTBL];
    int   nVec  = 0;
    int   nMiss = 0;

    // Reference state for the random phase
    logic [1:0] mPht[ENTRIES];
    logic       mPD, mPE;
    logic [5:0] mID, mIE, mGhr;

    function automatic vec_t mk(input logic r, input logic [31:0] pc,
                                input logic sD, input logic fD, input logic sE, input logic fE,
                                input logic br, input logic act, input logic eD, input logic eS);
        vec_t v;
        v.r = r; v.pc = pc; v.sD = sD; v.fD = fD; v.sE = sE; v.fE = fE;
        v.br = br; v.act = act; v.expD = eD; v.expS = eS;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst = v.r; pcF = v.pc; stallD = v.sD; flushD = v.fD;
        stallE = v.sE; flushE = v.fE; branchE = v.br; actual_takeE = v.act;
    endtask

    task automatic checkOut(input string tag, input int n, input vec_t v);
        exp_t e;
        #1;
        nVec++;
        if (sb.size() == 0) begin
            nMiss++;
            $display("FAIL %s[%0d] scoreboard empty", tag, n);
        end else begin
            e = sb.pop_front();
            $display("vec %s[%0d] rst=%b pc=%h sD=%b fD=%b sE=%b fE=%b br=%b act=%b predD=%b succE=%b",
                     tag, n, v.r, v.pc, v.sD, v.fD, v.sE, v.fE, v.br, v.act, pred_takeD, succE);
            if (pred_takeD !== e.expD || succE !== e.expS) begin
                nMiss++;
                $display("FAIL %s[%0d] pred_takeD got %b want %b, succE got %b want %b",
                         tag, n, pred_takeD, e.expD, succE, e.expS);
            end
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) mPht[i] = 2'b01;
        mPD = 1'b0; mPE = 1'b0; mID = '0; mIE = '0; mGhr = '0;
    endtask

    // Advance the reference model by one clock edge using the given inputs.
    task automatic modelStep(input vec_t v);
        logic [5:0] idx;
        logic       look;
        logic       tr;
        idx = v.pc[7:2];
`ifdef BP_GSHARE_EN
        idx = idx ^ mGhr;
`endif
        look = mPht[idx][1];
        tr   = v.br && !v.sE;
        if (v.r) begin
            modelReset();
        end else begin
            if (tr) begin
                if (v.act && mPht[mIE] != 2'b11) mPht[mIE] = mPht[mIE] + 2'd1;
                else if (!v.act && mPht[mIE] != 2'b00) mPht[mIE] = mPht[mIE] - 2'd1;
                mGhr = {mGhr[4:0], v.act};
            end
            if (v.fE) begin
                mPE = 1'b0; mIE = '0;
            end else if (!v.sE) begin
                mPE = mPD; mIE = mID;
            end
            if (v.fD) begin
                mPD = 1'b0; mID = '0;
            end else if (!v.sD) begin
                mPD = look; mID = idx;
            end
        end
    endtask

    task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        nVec++;
        $display("vec %s got=%0d want=%0d", tag, got, want);
        if (got !== want) begin
            nMiss++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    initial begin
        vec_t v;
        exp_t e;

        //        rst pc  sD fD sE fE br act  expD expS
        tbl[0]  = mk(0, PA, 0, 0, 0, 0, 0, 0,   0, 1);
        tbl[1]  = mk(0, PB, 0, 0, 0, 0, 0, 0,   0, 1);
        tbl[2]  = mk(0, PB, 0, 0, 0, 0, 1, 0,   0, 1);
        tbl[3]  = mk(0, P8, 0, 0, 0, 0, 1, 1,   0, 0);
        tbl[4]  = mk(0, PB, 0, 0, 0, 0, 1, 1,   0, 0);
        tbl[5]  = mk(0, PB, 0, 0, 0, 0, 0, 0,   1, 1);
        tbl[6]  = mk(0, PB, 0, 0, 0, 0, 1, 0,   1, 0);
        tbl[7]  = mk(0, PB, 0, 0, 0, 0, 1, 0,   1, 0);
        tbl[8]  = mk(0, PB, 0, 0, 0, 0, 1, 0,   1, 0);
        tbl[9]  = mk(0, PB, 0, 0, 0, 0, 1, 0,   0, 0);
        tbl[10] = mk(0, PB, 0, 0, 0, 0, 1, 0,   0, 1);
        tbl[11] = mk(0, PB, 0, 0, 0, 0, 0, 0,   0, 1);
        tbl[12] = mk(0, PB, 1, 0, 1, 0, 1, 1,   0, 0);
        tbl[13] = mk(0, PB, 1, 0, 1, 0, 1, 1,   0, 0);
        tbl[14] = mk(0, PB, 1, 0, 1, 0, 1, 1,   0, 0);
        tbl[15] = mk(0, PB, 0, 0, 0, 0, 1, 1,   0, 0);
        tbl[16] = mk(0, PB, 0, 0, 0, 0, 1, 1,   0, 0);
        tbl[17] = mk(0, PB, 0, 0, 0, 0, 0, 0,   0, 1);
        tbl[18] = mk(0, PB, 0, 0, 0, 0, 0, 0,   1, 1);
        tbl[19] = mk(0, PB, 1, 1, 0, 0, 0, 1,   1, 1);
        tbl[20] = mk(0, PA, 0, 0, 0, 0, 0, 0,   0, 0);
        tbl[21] = mk(0, P5, 0, 0, 0, 0, 0, 0,   0, 1);
        tbl[22] = mk(0, PA, 0, 0, 0, 0, 0, 0,   0, 1);
        tbl[23] = mk(0, P5, 0, 0, 0, 0, 1, 1,   0, 0);
        tbl[24] = mk(0, P5, 0, 0, 0, 0, 0, 0,   0, 1);
        tbl[25] = mk(0, PA, 0, 0, 0, 0, 0, 0,   1, 1);
        tbl[26] = mk(0, PA, 0, 0, 0, 1, 1, 1,   0, 1);
        tbl[27] = mk(0, P5, 0, 0, 0, 0, 0, 0,   0, 1);
        tbl[28] = mk(0, PA, 0, 0, 0, 0, 0, 0,   1, 1);
        tbl[29] = mk(0, PA, 0, 0, 0, 0, 1, 0,   0, 0);
        tbl[30] = mk(0, P5, 0, 0, 0, 0, 0, 0,   0, 1);
        tbl[31] = mk(0, PA, 0, 0, 0, 0, 0, 0,   1, 1);
        tbl[32] = mk(1, P5, 0, 0, 0, 0, 1, 1,   0, 1);
        tbl[33] = mk(0, P5, 0, 0, 0, 0, 0, 1,   0, 0);
        tbl[34] = mk(0, PA, 0, 0, 0, 0, 0, 0,   0, 1);

        repeat (2) @(posedge clk);

`ifndef BP_GSHARE_EN
        for (int i = 0; i < NTBL; i++) begin
            drive(tbl[i]);
            e.expD = tbl[i].expD;
            e.expS = tbl[i].expS;
            sb.push_back(e);
            checkOut("tbl", i, tbl[i]);
        end
`endif

        // Random phase: synchronise model and DUT through a reset cycle first.
        v = mk(1, PA, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        modelReset();
        for (int i = 0; i < NRND; i++) begin
            v.r   = ($urandom_range(0, 99) < 2);
            v.pc  = PA | (32'($urandom_range(0, 7)) << 2);
            v.sD  = ($urandom_range(0, 99) < 15);
            v.fD  = ($urandom_range(0, 99) < 8);
            v.sE  = ($urandom_range(0, 99) < 15);
            v.fE  = ($urandom_range(0, 99) < 8);
            v.br  = ($urandom_range(0, 99) < 60);
            v.act = 1'($urandom_range(0, 1));
            drive(v);
            e.expD = mPD;
            e.expS = (mPE == v.act);
            sb.push_back(e);
            checkOut("rnd", i, v);
            modelStep(v);
        end

`ifdef BP_GSHARE_EN
        // History after outcomes T,T,N and the hashed index for PC 0x00400000.
        v = mk(1, PA, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        v = mk(0, PA, 0, 0, 0, 0, 1, 1, 0, 0); drive(v);
        v = mk(0, PA, 0, 0, 0, 0, 1, 1, 0, 0); drive(v);
        v = mk(0, PA, 0, 0, 0, 0, 1, 0, 0, 0); drive(v);
        v = mk(0, PA, 0, 0, 0, 0, 0, 0, 0, 0); drive(v);
        #1;
        chkVal("ghr_ttn", 32'(dut.ghr), 32'd6);
        chkVal("idx_gshare", 32'(dut.idxF), 32'd6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
